// File: rtl/frame_buffer_pkg.sv
// Shared constants for the dual-port frame buffer: clear FSM encoding and
// the supported read-latency range.
package frame_buffer_pkg;
   localparam logic [1:0] FB_IDLE  = 2'd0;
   localparam logic [1:0] FB_CLEAR = 2'd1;
   localparam logic [1:0] FB_DONE  = 2'd2;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 2;
endpackage

// File: rtl/fb_clear_ctrl.sv
// Clear-sweep FSM and write-port arbitration: the sweep owns the write port
// while clearing, external writes are dropped and flagged.
module fb_clear_ctrl
   import frame_buffer_pkg::*;
#(
   parameter int             AW        = 15,
   parameter int             DW        = 8,
   parameter logic [DW-1:0]  CLEAR_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clear_req,
   input  logic          i_regwrite,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_data,
   output logic          o_busy,
   output logic          o_clear_done,
   output logic          o_wr_dropped,
   output logic          o_we,
   output logic [AW-1:0] o_waddr,
   output logic [DW-1:0] o_wdata
);
   localparam logic [AW-1:0] LAST = {AW{1'b1}};

   logic [1:0]    r_state;
   logic [AW-1:0] r_cnt;
   logic          r_wr_dropped;
   logic          w_sweep;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= FB_IDLE;
         r_cnt        <= '0;
         r_wr_dropped <= 1'b0;
      end else begin
         r_wr_dropped <= i_regwrite && (r_state == FB_CLEAR);
         case (r_state)
            FB_IDLE:
               if (i_clear_req) begin
                  r_state <= FB_CLEAR;
                  r_cnt   <= '0;
               end
            // counter parks on the last address instead of wrapping
            FB_CLEAR:
               if (r_cnt == LAST) r_state <= FB_DONE;
               else               r_cnt   <= r_cnt + 1'b1;
            FB_DONE: begin
               r_state <= FB_IDLE;
               r_cnt   <= '0;
            end
            default: r_state <= FB_IDLE;
         endcase
      end
   end

   assign w_sweep      = (r_state == FB_CLEAR);
   assign o_busy       = (r_state != FB_IDLE);
   assign o_clear_done = (r_state == FB_DONE);
   assign o_wr_dropped = r_wr_dropped;

   // nothing is written in a reset cycle, sweep or external
   assign o_we    = !rst && (w_sweep || i_regwrite);
   assign o_waddr = w_sweep ? r_cnt     : i_addr;
   assign o_wdata = w_sweep ? CLEAR_VAL : i_data;
endmodule

// File: rtl/frame_buffer_dp.sv
// Dual-port frame buffer: one write and one read per cycle, write-first
// bypass on collision, 1- or 2-cycle read latency, hardware clear sweep.
module frame_buffer_dp
   import frame_buffer_pkg::*;
#(
   parameter int             AW        = 15,
   parameter int             DW        = 8,
   parameter int             READ_LAT  = 1,
   parameter logic [DW-1:0]  CLEAR_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr_in,
   input  logic [DW-1:0] data_in,
   input  logic          regwrite,
   input  logic [AW-1:0] addr_out,
   input  logic          rd_en,
   output logic [DW-1:0] data_out,
   output logic          data_valid,
   input  logic          clear_req,
   output logic          busy,
   output logic          clear_done,
   output logic          wr_dropped
);
   localparam int NPOS = 2 ** AW;

   generate
      if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
         $error("frame_buffer_dp: READ_LAT must be 1 or 2");
      end
   endgenerate

   logic [DW-1:0]       r_ram [NPOS];
   logic [READ_LAT:1]   r_vld_pipe;
   logic [DW-1:0]       r_d1;
   logic                w_we;
   logic [AW-1:0]       w_waddr;
   logic [DW-1:0]       w_wdata;
   logic [DW-1:0]       w_rd;

   fb_clear_ctrl #(.AW(AW), .DW(DW), .CLEAR_VAL(CLEAR_VAL)) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .i_clear_req  (clear_req),
      .i_regwrite   (regwrite),
      .i_addr       (addr_in),
      .i_data       (data_in),
      .o_busy       (busy),
      .o_clear_done (clear_done),
      .o_wr_dropped (wr_dropped),
      .o_we         (w_we),
      .o_waddr      (w_waddr),
      .o_wdata      (w_wdata)
   );

   always_ff @(posedge clk) begin
      if (w_we) r_ram[w_waddr] <= w_wdata;
   end

   assign w_rd = (w_we && w_waddr == addr_out) ? w_wdata : r_ram[addr_out];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_pipe <= '0;
         r_d1       <= '0;
      end else begin
         r_vld_pipe[1] <= rd_en;
         for (int i = 2; i <= READ_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
         if (rd_en) r_d1 <= w_rd;
      end
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic [DW-1:0] r_d2;
         always_ff @(posedge clk) begin
            if (rst)                r_d2 <= '0;
            else if (r_vld_pipe[1]) r_d2 <= r_d1;
         end
         assign data_out = r_d2;
      end else begin : g_lat1
         assign data_out = r_d1;
      end
   endgenerate

   assign data_valid = r_vld_pipe[READ_LAT];
endmodule

// File: tb/tb_frame_buffer_dp.sv
// Drives a READ_LAT=1 and a READ_LAT=2 buffer in lockstep and checks both
// against a behavioural memory model plus directed expectations.
module tb_frame_buffer_dp;
   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, clear_req, regwrite, rd_en;
   logic [3:0] addr_in, addr_out;
   logic [7:0] data_in;
   logic [7:0] dout1, dout2;
   logic       dv1, dv2, busy1, busy2, cd1, cd2, wdr1, wdr2;

   frame_buffer_dp #(.AW(4), .DW(8), .READ_LAT(1), .CLEAR_VAL(8'h00)) u1 (
      .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
      .regwrite(regwrite), .addr_out(addr_out), .rd_en(rd_en),
      .data_out(dout1), .data_valid(dv1), .clear_req(clear_req),
      .busy(busy1), .clear_done(cd1), .wr_dropped(wdr1));

   frame_buffer_dp #(.AW(4), .DW(8), .READ_LAT(2), .CLEAR_VAL(8'h00)) u2 (
      .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
      .regwrite(regwrite), .addr_out(addr_out), .rd_en(rd_en),
      .data_out(dout2), .data_valid(dv2), .clear_req(clear_req),
      .busy(busy2), .clear_done(cd2), .wr_dropped(wdr2));

   int total = 0, passes = 0;
   int busy_cnt = 0, done_cnt = 0, done_at = 0, edge_n = 0;

   // reference model: memory image, clear mode (0 idle,1 sweeping,2 done)
   logic [7:0] mem [16];
   int         mode = 0, pos = 0;
   logic [7:0] e1d = 0, e2d = 0, pd = 0;
   logic       e1v = 0, e2v = 0, pv = 0, edrop = 0;

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic cyc(input logic r, input logic cr, input logic we,
                      input logic [3:0] wa, input logic [7:0] wd,
                      input logic re, input logic [3:0] ra);
      logic       wen;
      logic [3:0] wadr;
      logic [7:0] wdat, rdv;
      rst = r; clear_req = cr; regwrite = we; addr_in = wa; data_in = wd;
      rd_en = re; addr_out = ra;
      if (r) begin
         mode = 0; pos = 0; e1d = 0; e1v = 0; e2d = 0; e2v = 0;
         pd = 0; pv = 0; edrop = 0;
      end else begin
         wen = 0; wadr = 0; wdat = 0;
         if (mode == 1) begin wen = 1; wadr = 4'(pos); wdat = 8'h00; end
         else if (we)   begin wen = 1; wadr = wa; wdat = wd; end
         edrop = (mode == 1) && we;
         rdv = (wen && wadr == ra) ? wdat : mem[ra];
         e1v = re;
         if (re) e1d = rdv;
         e2v = pv;
         if (pv) e2d = pd;
         pv = re;
         if (re) pd = rdv;
         if (wen) mem[wadr] = wdat;
         case (mode)
            0: if (cr) begin mode = 1; pos = 0; end
            1: if (pos == 15) mode = 2; else pos++;
            default: mode = 0;
         endcase
      end
      @(posedge clk); #1;
      edge_n++;
      if (busy1) busy_cnt++;
      if (cd1) begin done_cnt++; done_at = edge_n; end
      chk1("u1.data_valid", dv1, e1v);
      chk8("u1.data_out", dout1, e1d);
      chk1("u2.data_valid", dv2, e2v);
      chk8("u2.data_out", dout2, e2d);
      chk1("u1.busy", busy1, mode != 0);
      chk1("u2.busy", busy2, mode != 0);
      chk1("u1.clear_done", cd1, mode == 2);
      chk1("u2.clear_done", cd2, mode == 2);
      chk1("u1.wr_dropped", wdr1, edrop);
      chk1("u2.wr_dropped", wdr2, edrop);
      @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      cyc(0, 0, 1, a, d, 0, 0);
   endtask
   task automatic rd(input logic [3:0] a);
      cyc(0, 0, 0, 0, 0, 1, a);
   endtask
   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic creq();
      cyc(0, 1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1; clear_req = 0; regwrite = 0; rd_en = 0;
      addr_in = 0; addr_out = 0; data_in = 0;
      @(negedge clk);
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk8("reset.data_out", dout1, 8'h00);
      chk1("reset.data_valid", dv1, 1'b0);
      chk1("reset.busy", busy1, 1'b0);

      // basic write then read, both latencies
      wr(3, 8'hA5);
      rd(3);
      chk8("s1.lat1.data", dout1, 8'hA5);
      chk1("s1.lat1.valid", dv1, 1'b1);
      chk1("s1.lat2.early", dv2, 1'b0);
      idle();
      chk8("s1.lat2.data", dout2, 8'hA5);
      chk1("s1.lat2.valid", dv2, 1'b1);

      // same-cycle collision
      cyc(0, 0, 1, 7, 8'h3C, 1, 7);
      chk8("s2.bypass", dout1, 8'h3C);
      rd(7);
      chk8("s2.reread", dout1, 8'h3C);

      // full clear sweep
      for (int a = 0; a < 16; a++) wr(4'(a), 8'hFF);
      busy_cnt = 0; done_cnt = 0; edge_n = 0;
      creq();
      repeat (20) idle();
      chki("s3.busy_cycles", busy_cnt, 17);
      chki("s3.done_pulses", done_cnt, 1);
      chki("s3.done_edge", done_at, 17);
      for (int a = 0; a < 16; a++) begin
         rd(4'(a));
         chk8("s3.cleared", dout1, 8'h00);
      end

      // dropped write and ignored re-request during a sweep
      for (int a = 0; a < 16; a++) wr(4'(a), 8'hFF);
      done_cnt = 0;
      creq();
      idle();
      idle();
      wr(2, 8'h55);
      chk1("s4.wr_dropped", wdr1, 1'b1);
      creq();
      repeat (20) idle();
      chki("s4.done_pulses", done_cnt, 1);
      rd(2);
      chk8("s4.addr2", dout1, 8'h00);

      // reset aborts sweep at count 5
      for (int a = 0; a < 16; a++) wr(4'(a), 8'hFF);
      rd(9);
      chk8("s5.pre", dout1, 8'hFF);
      creq();
      repeat (5) idle();
      cyc(1, 0, 0, 0, 0, 1, 9);
      chk1("s5.busy", busy1, 1'b0);
      chk1("s5.valid", dv1, 1'b0);
      chk8("s5.data", dout1, 8'h00);
      chk8("s5.data2", dout2, 8'h00);
      for (int a = 0; a < 16; a++) begin
         rd(4'(a));
         chk8("s5.partial", dout1, (a < 5) ? 8'h00 : 8'hFF);
      end

      // random traffic with occasional clears and resets
      repeat (2000) begin
         cyc($urandom_range(0, 499) == 0, $urandom_range(0, 149) == 0,
             1'($urandom), 4'($urandom), 8'($urandom),
             1'($urandom), 4'($urandom));
      end
      idle();
      idle();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
